// File: rtl/dac_cal_scheduler.sv
// dac_cal_scheduler
// -----------------
// Time-shares one 8-bit R2R DAC channel between live video and a calibration
// ramp. During active video the DAC always carries video_code. After a
// cal_start request the DAC is stepped through a code ramp, but only while
// vblank is high. The sweep pauses when blanking ends and resumes in the next
// frame. One sample strobe is issued per code for the external measurement path.
//
// Parameters
//   DWELL       cycles each calibration code is held while running (1..255)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   vblank      vertical blanking; calibration owns the DAC only while high
//   video_code  live colour code
//   cal_start   sweep request, accepted only when idle
//   cal_abort   cancel a sweep in progress
//   cal_step    code increment latched at start (0 behaves as 1)
//   dac_code    registered code to the R2R DAC inputs
//   dac_sel_cal registered; 1 while dac_code carries the calibration code
//   cal_code    current calibration code
//   cal_strobe  registered; marks the last dwell cycle of a code on dac_code
//   cal_busy    high while a sweep is armed, running or paused
//   cal_done    one-cycle pulse when a sweep completes normally
module dac_cal_scheduler #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblank,
  input  logic [7:0] video_code,
  input  logic       cal_start,
  input  logic       cal_abort,
  input  logic [7:0] cal_step,
  output logic [7:0] dac_code,
  output logic       dac_sel_cal,
  output logic [7:0] cal_code,
  output logic       cal_strobe,
  output logic       cal_busy,
  output logic       cal_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_e;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_e     state_q, state_d;
  logic [7:0] cal_code_q, cal_code_d;
  logic [7:0] dwell_q, dwell_d;
  logic [7:0] step_q, step_d;
  logic [7:0] dac_code_q;
  logic       dac_sel_cal_q;
  logic       cal_strobe_q;
  logic       cal_done_q;

  logic       run_live;
  logic       dwell_last;
  logic [8:0] next_code;

  // Calibration drives the DAC only while running and the live vblank is high,
  // so video regains the DAC one cycle after vblank falls, even before the
  // RUN->PAUSE transition has been registered.
  assign run_live   = (state_q == S_RUN) && vblank;
  assign dwell_last = (dwell_q == DWELL_LAST);
  // Nine bits so an overshoot past 255 ends the sweep instead of wrapping.
  assign next_code  = {1'b0, cal_code_q} + {1'b0, step_q};

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cal_code_d = cal_code_q;
    dwell_d    = dwell_q;
    step_d     = step_q;

    unique case (state_q)
      S_IDLE: begin
        if (cal_start && !cal_abort) begin
          state_d    = S_ARMED;
          step_d     = (cal_step == 8'd0) ? 8'd1 : cal_step;
          cal_code_d = 8'd0;
          dwell_d    = 8'd0;
        end
      end

      S_ARMED: begin
        if (cal_abort)   state_d = S_IDLE;
        else if (vblank) state_d = S_RUN;
      end

      S_RUN: begin
        if (cal_abort) begin
          state_d = S_IDLE;
        end else if (!vblank) begin
          // Code and dwell count are held so the sweep resumes where it stopped.
          state_d = S_PAUSE;
        end else if (dwell_last) begin
          dwell_d = 8'd0;
          if (next_code[8]) state_d    = S_DONE;
          else              cal_code_d = next_code[7:0];
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end

      S_PAUSE: begin
        if (cal_abort)   state_d = S_IDLE;
        else if (vblank) state_d = S_RUN;
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; reset is synchronous and overrides all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cal_code_q    <= 8'd0;
      dwell_q       <= 8'd0;
      step_q        <= 8'd1;
      dac_code_q    <= 8'd0;
      dac_sel_cal_q <= 1'b0;
      cal_strobe_q  <= 1'b0;
      cal_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cal_code_q    <= cal_code_d;
      dwell_q       <= dwell_d;
      step_q        <= step_d;
      dac_code_q    <= run_live ? cal_code_q : video_code;
      dac_sel_cal_q <= run_live;
      cal_strobe_q  <= run_live && dwell_last;
      // Registered from DONE so the pulse lands in the cycle after the final
      // strobe, when the state machine is already back in IDLE.
      cal_done_q    <= (state_q == S_DONE);
    end
  end

  assign dac_code    = dac_code_q;
  assign dac_sel_cal = dac_sel_cal_q;
  assign cal_code    = cal_code_q;
  assign cal_strobe  = cal_strobe_q;
  assign cal_busy    = (state_q == S_ARMED) || (state_q == S_RUN) || (state_q == S_PAUSE);
  assign cal_done    = cal_done_q;

endmodule
